// File: rtl/pwm_duty_ramp_pkg.sv
// Shared types and helpers for the PWM duty ramp stage and its prescaler.
package pwm_pkg;

  typedef enum logic {
    RAMP_IDLE,
    RAMP_RUN
  } ramp_state_t;

  // Full-scale duty for an r-bit PWM. The duty bus is one bit wider so that 100% is representable.
  function automatic logic [31:0] duty_max(input int unsigned r);
    return 32'(1) << r;
  endfunction

  function automatic logic [31:0] clamp_duty(input logic [31:0] v, input int unsigned r);
    return (v > duty_max(r)) ? duty_max(r) : v;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_tick_gen.sv
// 32-bit prescaler that pulses tick on the last count of each STEP_DIV-cycle period.
module pwm_tick_gen #(
  parameter int unsigned STEP_DIV = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(STEP_DIV - 1);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty slew stage: ramps duty one LSB per STEP_DIV clocks toward an accepted target.
// Optional mid-ramp retargeting is enabled by defining PWM_RAMP_RETARGET_EN.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned R        = 8,
  parameter int unsigned STEP_DIV = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [R:0] tgt_duty,
  output logic [R:0] duty,
  output logic       busy,
  output logic       done
);

  ramp_state_t state_q, state_d;
  logic [R:0]  tgt_q, tgt_d;
  logic [R:0]  duty_q, duty_d;
  logic        done_q, done_d;

  logic        xfer;
  logic        tick;
  logic        presc_clr;
  logic [R:0]  tgt_clamped;
  logic [R:0]  duty_stepped;

  assign tgt_clamped = (R+1)'(clamp_duty(32'(tgt_duty), R));

`ifdef PWM_RAMP_RETARGET_EN
  assign tgt_ready = 1'b1;
`else
  assign tgt_ready = (state_q == RAMP_IDLE);
`endif

  assign xfer      = tgt_valid && tgt_ready;
  assign presc_clr = xfer && (state_q == RAMP_IDLE);

  pwm_tick_gen #(
    .STEP_DIV(STEP_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr),
    .en  (state_q == RAMP_RUN),
    .tick(tick)
  );

  // Full-width compare so the direction can never be fooled by wrap-around.
  assign duty_stepped = (tgt_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    unique case (state_q)
      RAMP_IDLE: begin
        if (xfer) begin
          tgt_d = tgt_clamped;
          if (tgt_clamped == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP_RUN;
          end
        end
      end
      RAMP_RUN: begin
        if (tick) begin
          duty_d = duty_stepped;
          if (duty_stepped == tgt_q) begin
            state_d = RAMP_IDLE;
            done_d  = 1'b1;
          end
        end
`ifdef PWM_RAMP_RETARGET_EN
        // A new target overrides any completion decided above; it is judged against the post-step duty.
        if (xfer) begin
          tgt_d = tgt_clamped;
          if (tgt_clamped == duty_d) begin
            state_d = RAMP_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RAMP_RUN;
            done_d  = 1'b0;
          end
        end
`endif
      end
      default: state_d = RAMP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RAMP_IDLE;
      tgt_q   <= '0;
      duty_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

  assign duty = duty_q;
  assign busy = (state_q == RAMP_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp (R=8, STEP_DIV=4) using a timestamped step/done scoreboard.
module tb_pwm_duty_ramp;

  localparam int unsigned R    = 8;
  localparam int unsigned DIV  = 4;
  localparam int unsigned DMAX = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic [R:0] tgt_duty = '0;
  logic [R:0] duty;
  logic       busy;
  logic       done;

  pwm_duty_ramp #(
    .R       (R),
    .STEP_DIV(DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_duty (tgt_duty),
    .duty     (duty),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned d;
    int unsigned c;
  } step_t;

  typedef struct {
    int unsigned tgt;
    int unsigned exp_final;
  } vec_t;

  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned model_duty = 0;
  int unsigned prev_duty = 0;
  step_t       dq[$];
  int unsigned doneq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every duty change and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    step_t e;
    int unsigned c;
    if (rst) begin
      prev_duty = int'(duty);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_in_rst: done=%0b required 0", done);
      end
    end else begin
      if (int'(duty) != prev_duty) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_step: duty=%0d at cyc %0d, none required", duty, cyc);
        end else begin
          e = dq.pop_front();
          if (int'(duty) != e.d || cyc != e.c || int'(duty) > DMAX) begin
            errors++;
            $display("FAIL step: duty=%0d at cyc %0d, required %0d at cyc %0d", duty, cyc, e.d, e.c);
          end
        end
        prev_duty = int'(duty);
      end
      if (done === 1'b1) begin
        checks++;
        if (doneq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: at cyc %0d, none required", cyc);
        end else begin
          c = doneq.pop_front();
          if (cyc != c) begin
            errors++;
            $display("FAIL done_time: at cyc %0d, required cyc %0d", cyc, c);
          end
        end
      end
      checks++;
      if (busy !== (dq.size() != 0)) begin
        errors++;
        $display("FAIL busy: busy=%0b required %0b at cyc %0d", busy, dq.size() != 0, cyc);
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Called at negedge+2; queues the expected ramp and performs one transfer.
  task automatic xfer(input int unsigned tgt);
    int unsigned t, nt, n;
    t  = (tgt > DMAX) ? DMAX : tgt;
    nt = cyc + 1;
    check("ready_before_xfer", int'(tgt_ready), 1);
    if (t == model_duty) begin
      doneq.push_back(nt);
    end else begin
      n = (t > model_duty) ? t - model_duty : model_duty - t;
      for (int unsigned k = 1; k <= n; k++) begin
        dq.push_back('{d: (t > model_duty) ? model_duty + k : model_duty - k, c: nt + k * DIV});
      end
      doneq.push_back(nt + n * DIV);
    end
    model_duty = t;
    tgt_valid = 1'b1;
    tgt_duty  = (R+1)'(tgt);
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    @(negedge clk);
    #2;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned i;
    i = 0;
    while ((dq.size() != 0 || doneq.size() != 0) && i < budget) begin
      @(negedge clk);
      #2;
      i++;
    end
    checks++;
    if (dq.size() != 0 || doneq.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d steps and %0d dones outstanding", dq.size(), doneq.size());
      dq.delete();
      doneq.delete();
    end
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic wait_duty(input int unsigned v, input int unsigned budget);
    int unsigned i;
    i = 0;
    while (int'(duty) != v && i < budget) begin
      @(negedge clk);
      #2;
      i++;
    end
    check("reach_duty", int'(duty), v);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{tgt: 10,  exp_final: 10};
    vecs[1] = '{tgt: 7,   exp_final: 7};
    vecs[2] = '{tgt: 7,   exp_final: 7};
    vecs[3] = '{tgt: 300, exp_final: 256};
    vecs[4] = '{tgt: 256, exp_final: 256};
    vecs[5] = '{tgt: 250, exp_final: 250};
    vecs[6] = '{tgt: 0,   exp_final: 0};

    #1;
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(tgt_ready), 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;

    for (int i = 0; i < 7; i++) begin
      xfer(vecs[i].tgt);
      wait_idle(1200);
      check("final_duty", int'(duty), vecs[i].exp_final);
      check("idle_ready", int'(tgt_ready), 1);
    end

    // Retarget attempt mid-ramp 0 -> 20 at duty 12.
    xfer(20);
    wait_duty(12, 100);
`ifdef PWM_RAMP_RETARGET_EN
    check("ready_in_run", int'(tgt_ready), 1);
    dq.delete();
    doneq.delete();
    for (int unsigned k = 1; k <= 7; k++) dq.push_back('{d: 12 - k, c: cyc + k * DIV});
    doneq.push_back(cyc + 7 * DIV);
    model_duty = 5;
`else
    check("ready_in_run", int'(tgt_ready), 0);
`endif
    tgt_valid = 1'b1;
    tgt_duty  = 9'd5;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    wait_idle(200);
`ifdef PWM_RAMP_RETARGET_EN
    check("retarget_final", int'(duty), 5);
`else
    check("retarget_final", int'(duty), 20);
`endif

    // Reset mid-ramp as duty passes 15.
    xfer((model_duty < 15) ? 40 : 0);
    wait_duty(15, 200);
    rst = 1'b1;
    #1;
    check("midrst_duty", int'(duty), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(tgt_ready), 1);
    check("midrst_done", int'(done), 0);
    dq.delete();
    doneq.delete();
    model_duty = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    xfer(3);
    wait_idle(100);
    check("after_rst_final", int'(duty), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Duty-cycle slew stage that sits directly upstream of the enhanced PWM core and drives its R+1-bit duty input. It accepts a target duty through a valid/ready handshake. It then ramps its duty output one LSB per step period toward that target, giving glitch-free fades without per-channel sequencing logic. It flags completion with a one-cycle done pulse so a higher-level colour sequencer can chain fades.

Parameters:
R, 8, PWM resolution in bits; duty range is 0..2^R inclusive (R+1-bit bus).
STEP_DIV, 2_500_000, clk cycles per 1-LSB duty step; legal range 1..2^32-1.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
tgt_valid  input  1  target duty offered this cycle.
tgt_ready  output  1  block can accept a target this cycle.
tgt_duty  input  R+1  requested duty; values above 2^R are clamped to 2^R.
duty  output  R+1  registered duty to the PWM core.
busy  output  1  high while ramping (state RUN).
done  output  1  one-cycle pulse: duty has reached the accepted target.

Behaviour:
- Reset (async, immediate): duty=0, state=IDLE, prescaler=0, target=0, busy=0, done=0. tgt_ready=1 because the block is in IDLE.
- States (ramp_state_t): IDLE, RUN.
- tgt_ready is combinational from state: 1 in IDLE, 0 in RUN (see Optional Feature).
- Transfer occurs on a clk edge where tgt_valid && tgt_ready. The latched target is min(tgt_duty, 2^R).
- IDLE, transfer, target == duty: stay IDLE; done=1 for the next cycle only.
- IDLE, transfer, target != duty: go to RUN; prescaler=0; busy=1 from the next cycle.
- RUN prescaler: counts 0..STEP_DIV-1 and wraps to 0.
- RUN, edge where prescaler == STEP_DIV-1: duty <= duty+1 if target > duty, else duty-1.
- If that step makes duty equal target, on the same edge: state <= IDLE and done <= 1. The final duty and done are visible in the same cycle; busy drops that cycle.
- Latency: first step lands STEP_DIV cycles after the transfer edge. Total ramp time is |target - duty_start| * STEP_DIV cycles.
- STEP_DIV=1: one step per clock.
- Width rules:
  - duty is unsigned R+1 bits and never leaves 0..2^R.
  - No wrap-around: the direction decision compares full R+1-bit values.
  - The prescaler is 32 bits.
- Simultaneous events: tgt_valid in RUN is ignored (no transfer). done and a new transfer may coincide only in IDLE on the following cycle; the new transfer is processed normally.
- Reset mid-ramp: duty returns to 0 asynchronously, target is discarded, and no done pulse is produced.
- done is never asserted while rst is high.

Optional Feature:
Macro: PWM_RAMP_RETARGET_EN.
- Defined:
  - tgt_ready=1 in both states, so a transfer in RUN replaces the target.
  - The prescaler is not reset, which preserves step phase.
  - Direction is re-evaluated at the next step edge.
  - If the new clamped target equals the current duty, go to IDLE with a done pulse next cycle.
  - A transfer on the same edge as a step uses the post-step duty for the next comparison.
- Undefined: tgt_ready=0 in RUN, as above.

Decomposition:
- Package pwm_pkg:
  - ramp_state_t enum {RAMP_IDLE, RAMP_RUN}.
  - localparam-style function duty_max(R) = 2^R.
  - Function clamp_duty() for R+1-bit saturation.
- Sub-module pwm_tick_gen: 32-bit prescaler.
  - Inputs: clk, rst, clr, en. Output: tick, high on the cycle where count == STEP_DIV-1.
  - Reusable by the colour sequencer.
- The top level holds the FSM, the target register and the duty register.

Test Plan:
All scenarios use R=8, STEP_DIV=4 unless stated.
- Reset then transfer tgt_duty=10 -> duty steps 1,2,...,10 every 4 cycles; reaches 10 exactly 40 cycles after the transfer; done high 1 cycle; busy high 40 cycles.
- From duty=10, transfer tgt_duty=7 -> duty 9,8,7 at +4/+8/+12 cycles; done on cycle 12.
- Transfer tgt_duty=300 -> target clamps to 256; duty reaches 256 after 1024 cycles and never exceeds 256.
- From duty=7, transfer tgt_duty=7 -> busy stays 0; done pulses the cycle after the transfer; duty unchanged.
- Retargeting, ramping 0->20 with tgt_valid=1 and tgt_duty=5 at duty=12:
  - Macro undefined -> tgt_ready=0 and the ramp finishes at 20.
  - Macro defined -> duty reverses to 5 with step phase preserved; single done.
- Assert rst mid-ramp at duty=15 -> duty=0 asynchronously; busy=0; tgt_ready=1; no done pulse; a later transfer ramps from 0.
